// File: rtl/ifu.sv
// Instruction fetch unit: one 32-bit fetch per retired instruction over a
// single-outstanding valid/ready read channel, instruction held until retire.
module ifu #(
  parameter logic [31:0] MISALIGN_INST = 32'h00100073
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        pc_update_en,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        fetch_err,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_AR    = 2'd1,
    S_R     = 2'd2,
    S_VALID = 2'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] addr_q;
  logic [31:0] inst_q;
  logic        err_q;
  logic [31:0] cnt_q;
  logic        misaligned;

  assign misaligned = (pc[1:0] != 2'b00);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; misaligned PCs skip the bus entirely
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = misaligned ? S_VALID : S_AR;
      S_AR:    if (arready) state_d = S_R;
      S_R:     if (rvalid) state_d = S_VALID;
      S_VALID: if (pc_update_en) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state only
  always_comb begin
    arvalid    = 1'b0;
    rready     = 1'b0;
    inst_valid = 1'b0;
    case (state_q)
      S_AR:    arvalid    = 1'b1;
      S_R:     rready     = 1'b1;
      S_VALID: inst_valid = 1'b1;
      default: ;
    endcase
  end

  // Fetch address, held instruction, error flag and completion counter
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= 32'd0;
      inst_q <= 32'd0;
      err_q  <= 1'b0;
      cnt_q  <= 32'd0;
    end else begin
      if (state_q == S_IDLE) begin
        addr_q <= pc;
        if (misaligned) begin
          inst_q <= MISALIGN_INST;
          err_q  <= 1'b1;
        end
      end
      if ((state_q == S_R) && rvalid) begin
        inst_q <= rdata;
        err_q  <= (rresp != 2'b00);
      end
      if ((state_d == S_VALID) && (state_q != S_VALID)) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  assign araddr    = addr_q;
  assign inst      = inst_q;
  assign fetch_err = err_q;
  assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: reactive memory slave with programmable wait
// states, vector table, randomized fetches against a fetch-level model.
module tb_ifu;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        pc_update_en;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic        inst_valid;
  logic        fetch_err;
  logic [31:0] fetch_cnt;

  int          checks;
  int          errors;
  logic [31:0] exp_cnt;

  // slave configuration
  int          ar_wait;
  int          r_wait;
  logic [31:0] rd_word;
  logic [1:0]  rd_resp;
  logic        stray;
  int          ar_cnt;
  int          r_cnt;

  localparam logic [31:0] EBREAK = 32'h00100073;

  ifu dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_update_en(pc_update_en),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .inst(inst), .inst_valid(inst_valid), .fetch_err(fetch_err),
    .fetch_cnt(fetch_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory slave: reacts to the DUT's post-edge outputs; stray rvalid outside R
  initial begin
    arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'b00;
    ar_cnt = 0; r_cnt = 0;
    forever begin
      @(posedge clk); #2;
      if (arvalid === 1'b1) begin
        arready = (ar_cnt == ar_wait);
        ar_cnt++;
      end else begin
        arready = 1'b0;
        ar_cnt  = 0;
      end
      if (rready === 1'b1) begin
        rvalid = (r_cnt == r_wait);
        r_cnt++;
        rdata  = rd_word;
        rresp  = rd_resp;
      end else begin
        r_cnt  = 0;
        rvalid = stray;
        rdata  = 32'hbad0bad0;
        rresp  = 2'b11;
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_arvalid"},   32'(arvalid),    32'd0);
    chk({nm, "_rready"},    32'(rready),     32'd0);
    chk({nm, "_inst_valid"},32'(inst_valid), 32'd0);
    chk({nm, "_fetch_err"}, 32'(fetch_err),  32'd0);
    chk({nm, "_inst"},      inst,            32'd0);
    chk({nm, "_araddr"},    araddr,          32'd0);
    chk({nm, "_fetch_cnt"}, fetch_cnt,       32'd0);
  endtask

  // One fetch, starting with the DUT in IDLE; counts cycles until inst_valid
  task automatic do_fetch(input string nm, input logic [31:0] f_pc, input int aw,
                          input int rw, input logic [31:0] word, input logic [1:0] resp,
                          input logic [31:0] e_inst, input logic e_err, input int e_lat,
                          input logic st, input logic noise);
    int   lat;
    int   first_ar;
    logic done;
    logic addr_bad;
    logic overlap;
    pc = f_pc; ar_wait = aw; r_wait = rw; rd_word = word; rd_resp = resp; stray = st;
    lat = 0; first_ar = 0; done = 1'b0; addr_bad = 1'b0; overlap = 1'b0;
    while (!done && lat < 100) begin
      pc_update_en = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      tick;
      lat++;
      if (arvalid === 1'b1) begin
        if (first_ar == 0) first_ar = lat;
        if (araddr !== f_pc) addr_bad = 1'b1;
      end
      if (arvalid === 1'b1 && rready === 1'b1) overlap = 1'b1;
      if (inst_valid === 1'b1) done = 1'b1;
    end
    pc_update_en = 1'b0;
    stray = 1'b0;
    exp_cnt = exp_cnt + 32'd1;
    chk({nm, "_latency"},  32'(lat),       32'(e_lat));
    chk({nm, "_first_ar"}, 32'(first_ar),  (f_pc[1:0] == 2'b00) ? 32'd1 : 32'd0);
    chk({nm, "_araddr"},   32'(addr_bad),  32'd0);
    chk({nm, "_overlap"},  32'(overlap),   32'd0);
    chk({nm, "_inst"},     inst,           e_inst);
    chk({nm, "_err"},      32'(fetch_err), 32'(e_err));
    chk({nm, "_cnt"},      fetch_cnt,      exp_cnt);
  endtask

  // Hold in VALID for some cycles, then retire; DUT ends in IDLE
  task automatic retire(input string nm, input logic [31:0] e_inst, input logic e_err,
                        input int hold);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick;
      if (inst_valid !== 1'b1 || inst !== e_inst || fetch_err !== e_err) bad = 1'b1;
    end
    chk({nm, "_hold"}, 32'(bad), 32'd0);
    pc_update_en = 1'b1;
    tick;
    pc_update_en = 1'b0;
    chk({nm, "_retired"}, 32'(inst_valid), 32'd0);
  endtask

  typedef struct {
    logic [31:0] pc;
    int          aw;
    int          rw;
    logic [31:0] word;
    logic [1:0]  resp;
    logic [31:0] e_inst;
    logic        e_err;
    int          e_lat;
    logic        st;
  } vec_t;

  vec_t vt[7];

  initial begin
    logic [31:0] rpc;
    logic [31:0] rword;
    logic [1:0]  rrsp;
    int          raw;
    int          rrw;
    logic        mis;
    logic [31:0] e_inst;
    logic        e_err;
    int          e_lat;

    checks = 0; errors = 0; exp_cnt = 32'd0;
    ar_wait = 0; r_wait = 0; rd_word = 32'd0; rd_resp = 2'b00; stray = 1'b0;
    pc_update_en = 1'b0;

    // inputs, then expectations: zero-wait fetch latency is 3, misaligned is 1
    vt[0] = '{32'h80000004, 0, 0, 32'h00000013, 2'b00, 32'h00000013, 1'b0, 3, 1'b0};
    vt[1] = '{32'h80000008, 3, 2, 32'h00a00093, 2'b00, 32'h00a00093, 1'b0, 8, 1'b1};
    vt[2] = '{32'h8000000c, 0, 0, 32'hdeadbeef, 2'b10, 32'hdeadbeef, 1'b1, 3, 1'b0};
    vt[3] = '{32'h80000002, 0, 0, 32'h11111111, 2'b00, EBREAK,       1'b1, 1, 1'b0};
    vt[4] = '{32'h80000010, 1, 0, 32'h12345678, 2'b01, 32'h12345678, 1'b1, 4, 1'b0};
    vt[5] = '{32'h80000003, 2, 2, 32'h22222222, 2'b00, EBREAK,       1'b1, 1, 1'b1};
    vt[6] = '{32'h80000014, 0, 4, 32'hcafef00d, 2'b11, 32'hcafef00d, 1'b1, 7, 1'b0};

    // Reset then first fetch: arvalid in cycle 2, inst_valid in cycle 4
    rst = 1'b1; pc = 32'h80000000;
    tick; tick;
    rst = 1'b0;
    chk_reset_outputs("reset");
    do_fetch("first", 32'h80000000, 0, 0, 32'h00000413, 2'b00,
             32'h00000413, 1'b0, 3, 1'b0, 1'b0);
    retire("first", 32'h00000413, 1'b0, 10);

    for (int i = 0; i < 7; i++) begin
      do_fetch($sformatf("vec%0d", i), vt[i].pc, vt[i].aw, vt[i].rw, vt[i].word,
               vt[i].resp, vt[i].e_inst, vt[i].e_err, vt[i].e_lat, vt[i].st, 1'b0);
      retire($sformatf("vec%0d", i), vt[i].e_inst, vt[i].e_err, i % 3);
    end

    // Randomized fetches against the fetch-level model
    for (int i = 0; i < 40; i++) begin
      rpc   = $urandom;
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      rword = $urandom;
      rrsp  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      raw   = $urandom_range(0, 3);
      rrw   = $urandom_range(0, 3);
      mis   = (rpc % 4) != 0;
      e_inst = mis ? EBREAK : rword;
      e_err  = mis || (rrsp != 2'b00);
      e_lat  = mis ? 1 : 3 + raw + rrw;
      do_fetch($sformatf("rnd%0d", i), rpc, raw, rrw, rword, rrsp, e_inst, e_err, e_lat,
               1'($urandom_range(0, 1)), 1'b1);
      retire($sformatf("rnd%0d", i), e_inst, e_err, $urandom_range(0, 3));
    end

    // Reset while R awaits a withheld rvalid; late rvalid must be ignored
    pc = 32'h80000020; ar_wait = 0; r_wait = 1000; rd_word = 32'h55555555; rd_resp = 2'b00;
    tick;
    chk("midrst_ar", 32'(arvalid), 32'd1);
    tick; tick; tick;
    chk("midrst_r", 32'(rready), 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    exp_cnt = 32'd0;
    chk_reset_outputs("midrst");
    do_fetch("refetch", 32'h80000040, 1, 0, 32'h00c00113, 2'b00,
             32'h00c00113, 1'b0, 4, 1'b1, 1'b0);
    retire("refetch", 32'h00c00113, 1'b0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
